// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait/timeout FSM, branch and load-use
// handling, operand forwarding selects and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_wr,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_wr,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_wr,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [15:0] wait_q;
  logic        timeout_q;
  logic [15:0] stall_cnt_q, flush_cnt_q;

  logic mem_stall, load_use;

  assign mem_stall = (state_q != HALT) & dmem_req & ~dmem_ack;
  assign load_use  = ex_is_load & ex_reg_wr & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    fwd_a_sel    = 2'b00;
    fwd_b_sel    = 2'b00;
    if (!reset) begin
      if (state_q == HALT) begin
        memwb_bubble = 1'b1;
      end else if (mem_stall) begin
        // Front of the pipe holds; MEM/WB keeps draining bubbles behind the access.
        memwb_en     = 1'b1;
        memwb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        {idex_en, exmem_en, memwb_en} = 3'b111;
        idex_flush = 1'b1;
      end else begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
      end

      if (mem_reg_wr && mem_rd != 5'd0 && mem_rd == id_rs1)      fwd_a_sel = 2'b10;
      else if (wb_reg_wr && wb_rd != 5'd0 && wb_rd == id_rs1)    fwd_a_sel = 2'b01;
      if (mem_reg_wr && mem_rd != 5'd0 && mem_rd == id_rs2)      fwd_b_sel = 2'b10;
      else if (wb_reg_wr && wb_rd != 5'd0 && wb_rd == id_rs2)    fwd_b_sel = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= 16'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        RUN: if (mem_stall) begin
          state_q <= MEM_WAIT;
          wait_q  <= 16'd1;
        end
        MEM_WAIT: if (mem_stall) begin
          if (wait_q == WAIT_LAST) begin
            state_q   <= HALT;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end else begin
          // Ack (or a dropped request) releases the pipe.
          state_q <= RUN;
          wait_q  <= 16'd0;
        end
        HALT:    ;
        default: state_q <= RUN;
      endcase
      if (!pc_en && state_q != HALT && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if ((ifid_flush || idex_flush) && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
